shapool_sequencer: RTL and testbench

- Controls the hashing pool core for one job.
- Walks this device's nonce slice, starting from the nonce_start field of device_config.
- Steps the core through load, first-hash rounds, second-hash rounds and the target check for each nonce.
- Sits between external_io (start/halt, result hand-off) and the pool datapath; reports the exact winning nonce, so the host needs no off-by-one correction.

---
 rtl/shapool_sequencer.sv | 125 ++++++++++++
 tb/tb_shapool_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shapool_sequencer.sv
// Per-job sequencer for the hashing pool core: walks this device's nonce slice,
// steps the core through load/hash/hash/check and reports the winning nonce.
module shapool_sequencer #(
  parameter int NONCE_WIDTH    = 32,
  parameter int POOL_SIZE_LOG2 = 2,
  parameter int START_WIDTH    = 8,
  parameter int ROUND_COUNT    = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           halt,
  input  logic [START_WIDTH-1:0]         nonce_start,
  output logic                           core_load,
  output logic                           core_en,
  output logic                           core_phase,
  output logic [$clog2(ROUND_COUNT)-1:0] core_round,
  output logic [NONCE_WIDTH-1:0]         core_nonce,
  output logic                           core_check,
  input  logic                           core_match,
  output logic                           success,
  output logic                           found,
  output logic [NONCE_WIDTH-1:0]         result,
  output logic                           exhausted,
  output logic                           busy
);

  localparam int CNT_W   = NONCE_WIDTH - POOL_SIZE_LOG2;
  localparam int SLICE_W = CNT_W - START_WIDTH;
  localparam int RW      = $clog2(ROUND_COUNT);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUND_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HASH0,
    S_HASH1,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  counter;
  logic              round_last;
  logic              slice_last;

  assign round_last = (core_round == ROUND_LAST);
  assign slice_last = (counter[SLICE_W-1:0] == '1);

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start && !halt) next_state = S_LOAD;
      S_LOAD:  next_state = halt ? S_DONE : S_HASH0;
      S_HASH0: begin
        if (halt)            next_state = S_DONE;
        else if (round_last) next_state = S_HASH1;
      end
      S_HASH1: begin
        if (halt)            next_state = S_DONE;
        else if (round_last) next_state = S_CHECK;
      end
      // match outranks halt, which outranks slice exhaustion
      S_CHECK: next_state = (core_match || halt || slice_last) ? S_DONE : S_LOAD;
      S_DONE:  if (!start) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      counter    <= '0;
      core_round <= '0;
      success    <= 1'b0;
      found      <= 1'b0;
      result     <= '0;
      exhausted  <= 1'b0;
    end else begin
      state   <= next_state;
      success <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (next_state == S_LOAD) counter <= {nonce_start, {SLICE_W{1'b0}}};
          core_round <= '0;
        end
        S_LOAD: core_round <= '0;
        // the round index wraps to 0 on its own at HASH0->HASH1 and HASH1->CHECK
        S_HASH0, S_HASH1: begin
          if (next_state == S_DONE) core_round <= '0;
          else                      core_round <= core_round + 1'b1;
        end
        S_CHECK: begin
          if (core_match) begin
            success <= 1'b1;
            found   <= 1'b1;
            result  <= core_nonce;
          end else if (halt) begin
            found <= found;
          end else if (slice_last) begin
            exhausted <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            result    <= '0;
          end
        end
        default: core_round <= '0;
      endcase
    end
  end

  assign core_nonce = NONCE_WIDTH'(counter);
  assign core_load  = (state == S_LOAD);
  assign core_en    = (state == S_HASH0) || (state == S_HASH1);
  assign core_phase = (state == S_HASH1);
  assign core_check = (state == S_CHECK);
  assign busy       = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_shapool_sequencer.sv
// Scoreboard bench for shapool_sequencer: stimulus queues expected load/check/
// success/exhausted events, a negedge monitor pops and compares them.
module tb_shapool_sequencer;

  localparam int NW = 14;
  localparam int PL = 2;
  localparam int SW = 8;
  localparam int RC = 4;
  localparam int RW = $clog2(RC);

  localparam int K_LOAD    = 0;
  localparam int K_CHECK   = 1;
  localparam int K_SUCCESS = 2;
  localparam int K_EXH     = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          halt;
  logic [SW-1:0] nonce_start;
  logic          core_load;
  logic          core_en;
  logic          core_phase;
  logic [RW-1:0] core_round;
  logic [NW-1:0] core_nonce;
  logic          core_check;
  logic          core_match;
  logic          success;
  logic          found;
  logic [NW-1:0] result;
  logic          exhausted;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;
  ev_t exp_q[$];
  logic prev_exh = 1'b0;

  shapool_sequencer #(
    .NONCE_WIDTH(NW),
    .POOL_SIZE_LOG2(PL),
    .START_WIDTH(SW),
    .ROUND_COUNT(RC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .halt(halt),
    .nonce_start(nonce_start),
    .core_load(core_load),
    .core_en(core_en),
    .core_phase(core_phase),
    .core_round(core_round),
    .core_nonce(core_nonce),
    .core_check(core_check),
    .core_match(core_match),
    .success(success),
    .found(found),
    .result(result),
    .exhausted(exhausted),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: got kind %0d val 0x%0h expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_val", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_exh = 1'b0;
    end else begin
      if (core_load)              observe(K_LOAD, core_nonce);
      if (core_check)             observe(K_CHECK, core_nonce);
      if (success)                observe(K_SUCCESS, result);
      if (exhausted && !prev_exh) observe(K_EXH, core_nonce);
      prev_exh = exhausted;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},   core_load, 0);
    check({tag, "_en"},     core_en, 0);
    check({tag, "_phase"},  core_phase, 0);
    check({tag, "_round"},  core_round, 0);
    check({tag, "_nonce"},  core_nonce, 0);
    check({tag, "_check"},  core_check, 0);
    check({tag, "_succ"},   success, 0);
    check({tag, "_found"},  found, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_exh"},    exhausted, 0);
    check({tag, "_busy"},   busy, 0);
  endtask

  // Steps until the job leaves the busy states; asserts core_match / halt on
  // the n-th CHECK seen (0 = never).
  task automatic run_until_done(input int match_at, input int halt_at, input int limit);
    int  n = 0;
    bit  seen_busy = 1'b0;
    bit  done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      step();
      core_match = 1'b0;
      if (busy) seen_busy = 1'b1;
      if (core_check) begin
        n++;
        if (n == match_at) core_match = 1'b1;
        if (n == halt_at)  halt = 1'b1;
      end
      if (seen_busy && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL job_timeout: got busy after %0d cycles expected done", limit);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    halt        = 1'b0;
    core_match  = 1'b0;
    nonce_start = '0;
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // first job: timing of one nonce, then match on the third check
    push(K_LOAD, 'h050); push(K_CHECK, 'h050);
    push(K_LOAD, 'h051); push(K_CHECK, 'h051);
    push(K_LOAD, 'h052); push(K_CHECK, 'h052);
    push(K_SUCCESS, 'h052);
    nonce_start = 8'h05;
    start = 1'b1;
    step();
    check("t1_load", core_load, 1);
    check("t1_nonce", core_nonce, 'h0050);
    check("t1_busy", busy, 1);
    check("t1_load_en", core_en, 0);
    for (int ph = 0; ph < 2; ph++) begin
      for (int r = 0; r < RC; r++) begin
        step();
        check("t1_en", core_en, 1);
        check("t1_phase", core_phase, ph);
        check("t1_round", core_round, r);
        check("t1_nonce_stable", core_nonce, 'h0050);
      end
    end
    step();
    check("t1_check", core_check, 1);
    check("t1_check_en", core_en, 0);
    run_until_done(2, 0, 100);
    check("t1_success", success, 1);
    check("t1_found", found, 1);
    check("t1_result", result, 'h0052);
    check("t1_busy_done", busy, 0);
    check("t1_en_done", core_en, 0);
    step();
    check("t1_success_pulse", success, 0);
    check("t1_found_hold", found, 1);
    check("t1_result_hold", result, 'h0052);
    check("t1_en_hold", core_en, 0);
    start = 1'b0;
    step();
    check("t1_found_clr", found, 0);
    check("t1_result_clr", result, 0);

    // halt in IDLE blocks start, then halt during HASH1 round 2
    halt = 1'b1;
    nonce_start = 8'h12;
    start = 1'b1;
    step(); step(); step();
    check("t2_blocked_busy", busy, 0);
    check("t2_blocked_load", core_load, 0);
    push(K_LOAD, 'h120);
    halt = 1'b0;
    step();
    check("t2_load", core_load, 1);
    for (int i = 0; i < RC + 3; i++) step();
    check("t2_phase", core_phase, 1);
    check("t2_round", core_round, 2);
    halt = 1'b1;
    step();
    check("t2_busy", busy, 0);
    check("t2_en", core_en, 0);
    check("t2_success", success, 0);
    check("t2_found", found, 0);
    check("t2_result", result, 0);
    check("t2_exh", exhausted, 0);
    start = 1'b0;
    step();
    halt = 1'b0;
    check("t2_idle_busy", busy, 0);
    check("t2_idle_found", found, 0);

    // slice exhaustion at the top slice: no wrap past 0x0FFF
    for (int i = 0; i < 16; i++) begin
      push(K_LOAD, 'h0FF0 + i);
      push(K_CHECK, 'h0FF0 + i);
    end
    push(K_EXH, 'h0FFF);
    nonce_start = 8'hFF;
    start = 1'b1;
    run_until_done(0, 0, 300);
    check("t3_exh", exhausted, 1);
    check("t3_found", found, 0);
    check("t3_success", success, 0);
    check("t3_nonce", core_nonce, 'h0FFF);
    step();
    check("t3_exh_hold", exhausted, 1);
    check("t3_load_none", core_load, 0);
    start = 1'b0;
    step();
    check("t3_exh_clr", exhausted, 0);

    // halt and match in the same CHECK: match wins
    push(K_LOAD, 'h330); push(K_CHECK, 'h330); push(K_SUCCESS, 'h330);
    nonce_start = 8'h33;
    start = 1'b1;
    run_until_done(1, 1, 100);
    check("t4_success", success, 1);
    check("t4_found", found, 1);
    check("t4_result", result, 'h0330);
    halt = 1'b0;
    start = 1'b0;
    step();
    check("t4_found_clr", found, 0);

    // asynchronous reset mid-HASH0, then restart from the slice base
    push(K_LOAD, 'h070);
    nonce_start = 8'h07;
    start = 1'b1;
    step(); step(); step();
    check("t5_en_pre", core_en, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    push(K_LOAD, 'h070); push(K_CHECK, 'h070); push(K_SUCCESS, 'h070);
    step();
    reset_n = 1'b1;
    run_until_done(1, 0, 100);
    check("t5_result", result, 'h0070);
    check("t5_found", found, 1);
    start = 1'b0;
    step();
    step();

    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
